// File: rtl/itch_moldudp_deframer.sv
// MoldUDP64 block deframer: strips 2-byte length prefixes from 32-bit AXIS words and emits one ITCH byte
// per beat with tlast on each message's final byte. Stat counters are built only with ITCH_DEFRAMER_STATS_EN.
//   state     | meaning
//   S_LEN_HI  | waiting for length high byte
//   S_LEN_LO  | waiting for length low byte
//   S_PAYLOAD | forwarding message bytes
//   S_DROP    | discarding an oversize block
module itch_moldudp_deframer #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int MAX_MSG_LEN            = 64,
  parameter int CNT_W                  = 32
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                                  s00_axis_tlast,
  input  logic                                  s00_axis_tvalid,
  output logic                                  s00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic                                  m00_axis_tlast,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic [CNT_W-1:0]                      stat_msg_cnt,
  output logic [CNT_W-1:0]                      stat_drop_cnt,
  output logic [CNT_W-1:0]                      stat_trunc_cnt
);

  localparam int NL = C_S00_AXIS_TDATA_WIDTH / 8;
  localparam int LW = (NL > 1) ? $clog2(NL) : 1;

  typedef enum logic [1:0] {S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_DROP} state_t;

  state_t                              state_q, state_d;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   buf_data_q, buf_data_d;
  logic [NL-1:0]                       buf_mask_q, buf_mask_d;
  logic                                buf_last_q, buf_last_d;
  logic [7:0]                          len_hi_q, len_hi_d;
  logic [15:0]                         rem_q, rem_d;
  logic                                out_valid_q, out_valid_d;
  logic                                out_last_q, out_last_d;
  logic [7:0]                          out_data_q, out_data_d;
  logic                                run_q;

  logic [LW-1:0] lane_sel;
  logic [7:0]    cur_byte;
  logic [NL-1:0] mask_after;
  logic [15:0]   len_full;
  logic          consume, pkt_end, accept;
  logic          inc_msg, inc_drop, inc_trunc;

  always_comb begin
    lane_sel = '0;
    for (int i = NL - 1; i >= 0; i--) begin
      if (buf_mask_q[i]) lane_sel = LW'(i);
    end
  end

  assign cur_byte   = buf_data_q[{lane_sel, 3'b000} +: 8];
  assign mask_after = buf_mask_q & ~(NL'(1) << lane_sel);
  assign len_full   = {len_hi_q, cur_byte};
  assign consume    = run_q & (|buf_mask_q) & (~out_valid_q | m00_axis_tready);
  assign pkt_end    = consume & buf_last_q & ~(|mask_after);
  // run_q keeps tready low through reset and the first cycle after release
  assign s00_axis_tready = run_q & (~(|buf_mask_q) | (consume & ~(|mask_after)));
  assign accept          = s00_axis_tvalid & s00_axis_tready;

  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    rem_d       = rem_q;
    buf_data_d  = buf_data_q;
    buf_mask_d  = buf_mask_q;
    buf_last_d  = buf_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    inc_msg     = 1'b0;
    inc_drop    = 1'b0;
    inc_trunc   = 1'b0;
    if (out_valid_q && m00_axis_tready) out_valid_d = 1'b0;
    if (consume) begin
      buf_mask_d = mask_after;
      unique case (state_q)
        S_LEN_HI: begin
          len_hi_d = cur_byte;
          state_d  = S_LEN_LO;
        end
        S_LEN_LO: begin
          rem_d = len_full;
          if (len_full == 16'd0) begin
            inc_drop = 1'b1;
            state_d  = S_LEN_HI;
          end else if (len_full > 16'(MAX_MSG_LEN)) begin
            inc_drop = 1'b1;
            state_d  = S_DROP;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          out_valid_d = 1'b1;
          out_data_d  = cur_byte;
          out_last_d  = 1'b0;
          if (rem_q == 16'd1) begin
            out_last_d = 1'b1;
            inc_msg    = 1'b1;
            state_d    = S_LEN_HI;
          end else begin
            rem_d = rem_q - 16'd1;
            if (pkt_end) begin
              out_last_d = 1'b1;
              inc_trunc  = 1'b1;
            end
          end
        end
        S_DROP: begin
          if (rem_q == 16'd1) state_d = S_LEN_HI;
          else                rem_d   = rem_q - 16'd1;
        end
      endcase
      if (pkt_end) state_d = S_LEN_HI;
    end
    if (accept) begin
      buf_data_d = s00_axis_tdata;
      buf_mask_d = s00_axis_tstrb;
      buf_last_d = s00_axis_tlast;
      // an empty-strobe word still carries the packet boundary
      if (~(|s00_axis_tstrb) && s00_axis_tlast) state_d = S_LEN_HI;
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q     <= S_LEN_HI;
      buf_data_q  <= '0;
      buf_mask_q  <= '0;
      buf_last_q  <= 1'b0;
      len_hi_q    <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_data_q  <= buf_data_d;
      buf_mask_q  <= buf_mask_d;
      buf_last_q  <= buf_last_d;
      len_hi_q    <= len_hi_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      run_q       <= 1'b1;
    end
  end

  assign m00_axis_tvalid = out_valid_q;
  assign m00_axis_tlast  = out_last_q;
  assign m00_axis_tdata  = {{(C_M00_AXIS_TDATA_WIDTH-8){1'b0}}, out_data_q};

`ifdef ITCH_DEFRAMER_STATS_EN
  logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d, drop_cnt_q, drop_cnt_d, trunc_cnt_q, trunc_cnt_d;

  always_comb begin
    msg_cnt_d   = msg_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    if (inc_msg   && !(&msg_cnt_q))   msg_cnt_d   = msg_cnt_q + CNT_W'(1);
    if (inc_drop  && !(&drop_cnt_q))  drop_cnt_d  = drop_cnt_q + CNT_W'(1);
    if (inc_trunc && !(&trunc_cnt_q)) trunc_cnt_d = trunc_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      msg_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      msg_cnt_q   <= msg_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign stat_msg_cnt   = msg_cnt_q;
  assign stat_drop_cnt  = drop_cnt_q;
  assign stat_trunc_cnt = trunc_cnt_q;
`else
  logic stats_unused;
  assign stats_unused   = inc_msg ^ inc_drop ^ inc_trunc;
  assign stat_msg_cnt   = '0;
  assign stat_drop_cnt  = '0;
  assign stat_trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_itch_moldudp_deframer.sv
// Scoreboard bench for itch_moldudp_deframer: a block-level packet model fills the expected-beat queue,
// a driver feeds words and an independent monitor compares each accepted output beat.
module tb_itch_moldudp_deframer;
  localparam int CNT_W = 32;
  localparam int MAXL  = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      s_tdata;
  logic [3:0]       s_tstrb;
  logic             s_tlast, s_tvalid, s_tready;
  logic [31:0]      m_tdata;
  logic             m_tlast, m_tvalid, m_tready;
  logic [CNT_W-1:0] stat_msg, stat_drop, stat_trunc;

  always #5 clk = ~clk;

  itch_moldudp_deframer #(
    .C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32), .MAX_MSG_LEN(MAXL), .CNT_W(CNT_W)
  ) dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb), .s00_axis_tlast(s_tlast),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tready(s_tready),
    .m00_axis_tdata(m_tdata), .m00_axis_tlast(m_tlast), .m00_axis_tvalid(m_tvalid),
    .m00_axis_tready(m_tready),
    .stat_msg_cnt(stat_msg), .stat_drop_cnt(stat_drop), .stat_trunc_cnt(stat_trunc)
  );

  typedef struct packed {logic [31:0] d; logic [3:0] s; logic l;} word_t;
  typedef struct packed {logic l; logic [7:0] b;} beat_t;

  word_t      word_q[$];
  word_t      stage_q[$];
  beat_t      exp_q[$];
  logic [7:0] pkt_q[$];
  int compared = 0, mismatched = 0, rx_cnt = 0;
  int m_msg = 0, m_drop = 0, m_trunc = 0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Block-level reference: walk length prefixes over the packet's byte stream.
  task automatic model_pkt();
    int n, pos, len, take;
    beat_t bt;
    n = pkt_q.size();
    pos = 0;
    while (n - pos >= 2) begin
      len = int'({pkt_q[pos], pkt_q[pos+1]});
      pos += 2;
      if (len == 0) m_drop++;
      else if (len > MAXL) begin
        m_drop++;
        pos += (len < n - pos) ? len : n - pos;
      end else begin
        take = (len < n - pos) ? len : n - pos;
        for (int k = 0; k < take; k++) begin
          bt.l = (k == take - 1);
          bt.b = pkt_q[pos+k];
          exp_q.push_back(bt);
        end
        pos += take;
        if (take == len) m_msg++;
        else if (take > 0) m_trunc++;
      end
    end
  endtask

  task automatic push_w(input logic [31:0] d, input logic [3:0] s, input logic l);
    word_t w;
    w.d = d; w.s = s; w.l = l;
    stage_q.push_back(w);
  endtask

  task automatic send_words();
    pkt_q.delete();
    foreach (stage_q[i])
      for (int ln = 0; ln < 4; ln++)
        if (stage_q[i].s[ln]) pkt_q.push_back(stage_q[i].d[ln*8 +: 8]);
    model_pkt();
    foreach (stage_q[i]) word_q.push_back(stage_q[i]);
    stage_q.delete();
    pkt_q.delete();
  endtask

  task automatic send_pkt(input bit rnd_strb);
    int pos, n;
    word_t w;
    pos = 0;
    n = pkt_q.size();
    while (pos < n) begin
      w.d = $urandom;
      w.s = 4'hF;
      w.l = 1'b0;
      if (rnd_strb) w.s = 4'($urandom_range(0, 15));
      if (w.s != 4'h0) begin
        for (int ln = 0; ln < 4; ln++)
          if (w.s[ln]) begin
            if (pos < n) begin w.d[ln*8 +: 8] = pkt_q[pos]; pos++; end
            else w.s[ln] = 1'b0;
          end
        w.l = (pos == n);
      end
      stage_q.push_back(w);
    end
    send_words();
  endtask

  task automatic add_d_block();
    pkt_q.push_back(8'h00); pkt_q.push_back(8'h09); pkt_q.push_back(8'h44);
    for (int k = 1; k <= 8; k++) pkt_q.push_back(8'(k));
  endtask

  task automatic stage_test1();
    push_w(32'h44000900, 4'hF, 1'b0);
    push_w(32'h04030201, 4'hF, 1'b0);
    push_w(32'h00080706, 4'h7, 1'b1);
  endtask

  task automatic gen_random_pkt();
    int nb, r, len, keep;
    nb = $urandom_range(1, 3);
    for (int b = 0; b < nb; b++) begin
      r = $urandom_range(0, 9);
      if (r == 0) len = 0;
      else if (r == 1) len = $urandom_range(MAXL + 1, 90);
      else len = $urandom_range(1, MAXL);
      pkt_q.push_back(8'(len >> 8));
      pkt_q.push_back(8'(len));
      for (int k = 0; k < len; k++) pkt_q.push_back(8'($urandom));
    end
    if ($urandom_range(0, 4) == 0) begin
      keep = $urandom_range(1, pkt_q.size());
      while (pkt_q.size() > keep) void'(pkt_q.pop_back());
    end
    send_pkt(1'b1);
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while ((word_q.size() != 0 || exp_q.size() != 0 || m_tvalid) && cyc < 20000) begin
      @(negedge clk); #2;
      cyc++;
    end
    chk({name, "_drained"}, {32'(word_q.size()), 32'(exp_q.size())}, 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_counters(input string name);
    int em, ed, et;
`ifdef ITCH_DEFRAMER_STATS_EN
    em = m_msg; ed = m_drop; et = m_trunc;
`else
    em = 0; ed = 0; et = 0;
`endif
    chk({name, "_msg_cnt"}, 64'(stat_msg), 64'(em));
    chk({name, "_drop_cnt"}, 64'(stat_drop), 64'(ed));
    chk({name, "_trunc_cnt"}, 64'(stat_trunc), 64'(et));
  endtask

  // input driver: handshake observed mid-cycle, next word presented just after the edge
  initial begin
    bit hs;
    s_tvalid = 1'b0; s_tdata = '0; s_tstrb = '0; s_tlast = 1'b0;
    forever begin
      @(negedge clk);
      hs = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (hs && word_q.size() > 0) void'(word_q.pop_front());
      if (word_q.size() > 0) begin
        s_tvalid = 1'b1;
        s_tdata  = word_q[0].d;
        s_tstrb  = word_q[0].s;
        s_tlast  = word_q[0].l;
      end else begin
        s_tvalid = 1'b0;
      end
    end
  end

  initial begin
    int ph;
    logic [3:0] pat;
    pat = 4'b1001;
    ph = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: begin m_tready = pat[3 - (ph % 4)]; ph++; end
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // monitor
  initial begin
    bit prev_stall;
    logic [32:0] prev_beat;
    beat_t e;
    prev_stall = 1'b0;
    prev_beat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 1'b0;
      else begin
        if (prev_stall)
          chk("stall_hold", {31'd0, m_tvalid, m_tlast, m_tdata}, {31'd0, 1'b1, prev_beat});
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL beat: unexpected output tdata=%0h tlast=%0b, expected none", m_tdata, m_tlast);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {31'd0, m_tlast, m_tdata}, {31'd0, e.l, 24'd0, e.b});
          end
          rx_cnt++;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_beat = {m_tlast, m_tdata};
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cyc;
    rst_n = 1'b0;
    #12;
    chk("reset_outputs", {30'd0, m_tvalid, m_tlast, s_tready, m_tdata}, 64'd0);
    check_counters("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single block from literal words
    base = rx_cnt;
    stage_test1();
    send_words();
    wait_idle("t1");
    chk("t1_beats", 64'(rx_cnt - base), 64'd9);
    check_counters("t1");

    // 2: two messages in one packet
    base = rx_cnt;
    add_d_block();
    pkt_q.push_back(8'h00); pkt_q.push_back(8'h03);
    pkt_q.push_back(8'h58); pkt_q.push_back(8'hAA); pkt_q.push_back(8'hBB);
    send_pkt(1'b0);
    wait_idle("t2");
    chk("t2_beats", 64'(rx_cnt - base), 64'd12);
    check_counters("t2");

    // 3: backpressure pattern
    rdy_mode = 1;
    base = rx_cnt;
    stage_test1();
    send_words();
    wait_idle("t3");
    chk("t3_beats", 64'(rx_cnt - base), 64'd9);
    rdy_mode = 0;

    // 4: oversize block dropped
    base = rx_cnt;
    pkt_q.push_back(8'h00); pkt_q.push_back(8'h41);
    for (int k = 0; k < 65; k++) pkt_q.push_back(8'($urandom));
    add_d_block();
    send_pkt(1'b0);
    wait_idle("t4");
    chk("t4_beats", 64'(rx_cnt - base), 64'd9);
    check_counters("t4");

    // 5: truncated message, then a normal packet
    base = rx_cnt;
    pkt_q.push_back(8'h00); pkt_q.push_back(8'h09);
    for (int k = 0; k < 5; k++) pkt_q.push_back(8'h10 + 8'(k));
    send_pkt(1'b0);
    wait_idle("t5");
    chk("t5_beats", 64'(rx_cnt - base), 64'd5);
    stage_test1();
    send_words();
    wait_idle("t5b");
    check_counters("t5");

    // randomized packets, strobes and backpressure
    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      gen_random_pkt();
      if (p % 10 == 9) begin
        wait_idle("rand");
        check_counters("rand");
      end
    end
    rdy_mode = 0;

    // 6: reset in mid-payload
    base = rx_cnt;
    stage_test1();
    send_words();
    cyc = 0;
    while (rx_cnt < base + 3 && cyc < 200) begin
      @(negedge clk); #2;
      cyc++;
    end
    chk("t6_mid_msg_reached", 64'(rx_cnt >= base + 3), 64'd1);
    rst_n = 1'b0;
    word_q.delete();
    exp_q.delete();
    m_msg = 0; m_drop = 0; m_trunc = 0;
    #1;
    chk("t6_reset_tvalid", {62'd0, m_tvalid, s_tready}, 64'd0);
    repeat (3) @(negedge clk);
    chk("t6_reset_outputs", {31'd0, m_tlast, m_tdata}, 64'd0);
    check_counters("t6_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    base = rx_cnt;
    stage_test1();
    send_words();
    wait_idle("t6");
    chk("t6_beats", 64'(rx_cnt - base), 64'd9);
    check_counters("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
